// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// pool_ctrl : streaming 2x2 signed max-pool controller with one-row line buffer
// Revision  : 1.0
// ============================================================================

module pool_max4 (
  input  logic [31:0] cnn_data,
  output logic [7:0]  pool_o
);
  logic signed [7:0] w_p0, w_p1, w_p2, w_p3, w_m01, w_m23;

  assign w_p0   = cnn_data[7:0];
  assign w_p1   = cnn_data[15:8];
  assign w_p2   = cnn_data[23:16];
  assign w_p3   = cnn_data[31:24];
  assign w_m01  = (w_p0 > w_p1) ? w_p0 : w_p1;
  assign w_m23  = (w_p2 > w_p3) ? w_p2 : w_p3;
  assign pool_o = (w_m01 > w_m23) ? w_m01 : w_m23;
endmodule

module pool_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             in_done_q, in_done_d;
  logic             out_valid_q, busy_q, frame_done_q;
  logic [7:0]       h0_q, out_data_q;
  logic [7:0]       lb_q [IMG_W];

  logic             w_odd_row, w_odd_col, w_in_ready, w_xfer, w_load, w_last_px;
  logic [COL_W-1:0] w_col_m1;
  logic [7:0]       w_pool;

  assign w_odd_row = row_q[0];
  assign w_odd_col = col_q[0];
  assign w_col_m1  = col_q - COL_W'(1);
  assign w_last_px = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);

  // Only the pixel completing a 2x2 window needs room in the output register.
  assign w_in_ready = (state_q == S_RUN) && !in_done_q &&
                      (!(w_odd_row && w_odd_col) || !out_valid_q || out_ready);
  assign w_xfer     = in_valid && w_in_ready;
  assign w_load     = w_xfer && w_odd_row && w_odd_col;

  pool_max4 u_pool (
    .cnn_data ({in_data, h0_q, lb_q[col_q], lb_q[w_col_m1]}),
    .pool_o   (w_pool)
  );

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    in_done_d = in_done_q;
    if (w_xfer) begin
      if (w_last_px) begin
        in_done_d = 1'b1;
      end else if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      in_done_q    <= 1'b0;
      h0_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            row_q     <= '0;
            col_q     <= '0;
            in_done_q <= 1'b0;
          end
        end
        S_RUN: begin
          row_q     <= row_d;
          col_q     <= col_d;
          in_done_q <= in_done_d;
          if (w_xfer && w_odd_row && !w_odd_col) begin
            h0_q <= in_data;
          end
          if (w_load) begin
            out_data_q  <= w_pool;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
          // Inputs exhausted, so the accepted output is the frame's last.
          if (in_done_q && out_valid_q && out_ready) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && !w_odd_row) begin
      lb_q[col_q] <= in_data;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule

`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pool_ctrl : randomized scoreboard bench for pool_ctrl (4x4, 2x2, 28x28)
// Revision     : 1.0
// ============================================================================
module tb_pool_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_r, in_valid, out_ready;
  logic [7:0] in_data;
  int         sel;

  logic st4, st2, st28;
  assign st4  = start_r && (sel == 0);
  assign st2  = start_r && (sel == 1);
  assign st28 = start_r && (sel == 2);

  logic       ir4, ov4, bz4, fd4, ir2, ov2, bz2, fd2, ir28, ov28, bz28, fd28;
  logic [7:0] od4, od2, od28;

  pool_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
    .busy(bz4), .frame_done(fd4));
  pool_ctrl #(.IMG_W(2), .IMG_H(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
    .busy(bz2), .frame_done(fd2));
  pool_ctrl #(.IMG_W(28), .IMG_H(28)) u_dut28 (
    .clk(clk), .rst(rst), .start(st28), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir28), .out_data(od28), .out_valid(ov28), .out_ready(out_ready),
    .busy(bz28), .frame_done(fd28));

  logic       m_ir, m_ov, m_bz, m_fd;
  logic [7:0] m_od;
  always_comb begin
    m_ir = ir28; m_ov = ov28; m_bz = bz28; m_fd = fd28; m_od = od28;
    case (sel)
      0: begin m_ir = ir4; m_ov = ov4; m_bz = bz4; m_fd = fd4; m_od = od4; end
      1: begin m_ir = ir2; m_ov = ov2; m_bz = bz2; m_fd = fd2; m_od = od2; end
      default: ;
    endcase
  end

  logic [7:0] px[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_e, last_out;
  int errors = 0, checks = 0;
  int cyc = 0, last_pop_cyc = -10, fd_cnt = 0;
  int ordy_mode = 0, ordy_pct = 100;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: signed maximum of the 2x2 window whose top-left is (r,c).
  function automatic logic [7:0] pool_ref(input int w, input int r, input int c);
    logic signed [7:0] m, v;
    m = px[r*w + c];
    v = px[r*w + c + 1];       if (v > m) m = v;
    v = px[(r+1)*w + c];       if (v > m) m = v;
    v = px[(r+1)*w + c + 1];   if (v > m) m = v;
    return m;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (ordy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(99) < ordy_pct);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pool_out", m_od, mon_e);
          last_out = m_od;
          if (exp_q.size() == 0) last_pop_cyc = cyc;
        end
      end
      if (m_fd) begin
        fd_cnt++;
        chk("frame_done_timing", cyc, last_pop_cyc + 1);
      end
    end
  end

  task automatic run_frame(input int w, input int h, input int n_px,
                           input int pvalid, input int glitch_at);
    int   i, budget, r, c, fd0;
    logic xfer;
    fd0 = fd_cnt;
    for (int pr = 0; pr < h/2; pr++)
      for (int pc = 0; pc < w/2; pc++)
        if ((2*pr + 1)*w + 2*pc + 1 < n_px) exp_q.push_back(pool_ref(w, 2*pr, 2*pc));
    @(posedge clk); #2; start_r = 1'b1;
    @(posedge clk); #2; start_r = 1'b0;
    chk("busy_in_run", m_bz, 1);
    i = 0;
    budget = 0;
    while (i < n_px && budget < 20000) begin
      in_data  = px[i];
      in_valid = ($urandom_range(99) < pvalid);
      start_r  = (i == glitch_at);
      @(negedge clk);
      xfer = in_valid && m_ir;
      @(posedge clk); #2;
      budget++;
      if (xfer) begin
        r = i / w;
        c = i % w;
        if (r % 2 == 1 && c % 2 == 1) begin
          chk("latency_valid", m_ov, 1);
          chk("latency_data", m_od, pool_ref(w, r - 1, c - 1));
        end
        i++;
      end
    end
    in_valid = 1'b0;
    start_r  = 1'b0;
    if (budget >= 20000) chk("input_timeout", i, n_px);
    if (n_px == w*h) begin
      chk("in_ready_after_last", m_ir, 0);
      budget = 0;
      while (fd_cnt == fd0 && budget < 5000) begin
        @(posedge clk);
        budget++;
      end
      if (budget >= 5000) chk("frame_done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #2;
      chk("frame_done_count", fd_cnt - fd0, 1);
      chk("busy_after_done", m_bz, 0);
      chk("scoreboard_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int budget;
    rst = 1'b1; start_r = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    out_ready = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", m_ir, 0);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_out_data", m_od, 0);
    chk("rst_busy", m_bz, 0);
    chk("rst_frame_done", m_fd, 0);
    rst = 1'b0;
    in_valid = 1'b0;

    // 4x4 ramp with free-flowing output
    px = {};
    for (int k = 0; k < 16; k++) px.push_back(8'(k));
    run_frame(4, 4, 16, 100, -1);
    chk("ramp_last_out", last_out, 15);

    // 2x2 signed frames
    sel = 1;
    px = {8'h80, 8'hFD, 8'hFF, 8'hF9};
    run_frame(2, 2, 4, 100, -1);
    chk("signed_neg1", last_out, 8'hFF);
    px = {8'h80, 8'h80, 8'h80, 8'h80};
    run_frame(2, 2, 4, 100, -1);
    chk("signed_min", last_out, 8'h80);

    // Backpressure: first output held while the second window is stalled
    sel = 0;
    px = {};
    for (int k = 0; k < 16; k++) px.push_back(8'(k));
    ordy_mode = 2;
    fork
      run_frame(4, 4, 16, 100, -1);
      begin
        repeat (20) @(posedge clk);
        #2;
        chk("bp_in_ready", m_ir, 0);
        chk("bp_hold_valid", m_ov, 1);
        chk("bp_hold_data", m_od, 5);
        ordy_mode = 0;
      end
    join

    // start pulsed mid-frame must be ignored
    px = {};
    for (int k = 0; k < 16; k++) px.push_back(8'($urandom_range(255)));
    run_frame(4, 4, 16, 100, 6);

    // Abort at row 2, then a clean frame
    px = {};
    for (int k = 0; k < 16; k++) px.push_back(8'($urandom_range(255)));
    run_frame(4, 4, 8, 100, -1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    chk("abort_drain", exp_q.size(), 0);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    chk("abort_out_valid", m_ov, 0);
    chk("abort_busy", m_bz, 0);
    px = {};
    for (int k = 0; k < 16; k++) px.push_back(8'($urandom_range(255)));
    run_frame(4, 4, 16, 100, -1);

    // 28x28 with random throttling on both sides
    sel = 2;
    ordy_mode = 1;
    ordy_pct = 60;
    px = {};
    for (int k = 0; k < 28*28; k++) px.push_back(8'($urandom_range(255)));
    run_frame(28, 28, 28*28, 70, -1);
    ordy_mode = 0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
